// File: rtl/aes_cmd_xactor_if.sv
// Bus bundle between the host command channel, the xactor and the AES core ports.
// The xactor takes the slave modport; the host/core side takes the master modport.
interface aes_cmd_xactor_if #(
  parameter int TAG_W = 4
);
  // host command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [255:0]     cmd_data;
  logic [TAG_W-1:0] cmd_tag;

  // host response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [127:0]     rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  // AES key-expansion bus
  logic [255:0]     key_out;
  logic [1:0]       key_mode;
  logic             key_start;
  logic             key_ready;

  // AES cipher bus
  logic [127:0]     c_data;
  logic             c_data_valid;
  logic             c_ende;
  logic             c_enable;
  logic             c_ready;
  logic [127:0]     c_odata;
  logic             c_odata_valid;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_tag,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  rsp_ready,
    output key_out, key_mode, key_start,
    input  key_ready,
    output c_data, c_data_valid, c_ende, c_enable,
    input  c_ready, c_odata, c_odata_valid
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_tag,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
    output rsp_ready,
    input  key_out, key_mode, key_start,
    output key_ready,
    input  c_data, c_data_valid, c_ende, c_enable,
    output c_ready, c_odata, c_odata_valid
  );
endinterface

// File: rtl/aes_cmd_xactor.sv
// Command transactor for the AES core: one command at a time (KEY/ENC/DEC),
// runs the key and cipher bus handshakes and returns one tagged response each.
module aes_cmd_xactor #(
  parameter int         TAG_W    = 4,
  parameter int         TIMEOUT  = 1024,
  parameter logic [1:0] KEY_MODE = 2'b10
) (
  input logic              clk,
  input logic              reset_n,
  aes_cmd_xactor_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_KEY  = 2'b00,
    OP_ENC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_KSTART,
    S_KSKIP,
    S_KWAIT,
    S_CWRDY,
    S_CSEND,
    S_CSKIP,
    S_CWAIT,
    S_RSP
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             tmo_last;
  logic             tmo_hit;
  logic [CNT_W-1:0] tmo_cnt;
  logic             key_loaded;
  op_t              lat_op;
  logic [127:0]     lat_data;

  logic [127:0]     rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;
  logic [255:0]     key_out_q;
  logic [1:0]       key_mode_q;
  logic [127:0]     c_data_q;
  logic             c_ende_q;
  logic             c_enable_q;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------- state register
  // NOTE: every clocked assignment is non-blocking so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------- next state
  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_t'(bus.cmd_op))
            OP_KEY:         state_next = S_KSTART;
            OP_ENC, OP_DEC: state_next = key_loaded ? S_CWRDY : S_RSP;
            default:        state_next = S_RSP;
          endcase
        end
      end
      S_KSTART: state_next = S_KSKIP;
      S_KSKIP:  state_next = S_KWAIT;
      S_KWAIT: begin
        if (bus.key_ready) begin
          state_next = S_RSP;
        end else if (tmo_last) begin
          state_next = S_RSP;
          tmo_hit    = 1'b1;
        end
      end
      S_CWRDY: begin
        if (bus.c_ready) begin
          state_next = S_CSEND;
        end else if (tmo_last) begin
          state_next = S_RSP;
          tmo_hit    = 1'b1;
        end
      end
      S_CSEND: state_next = S_CSKIP;
      S_CSKIP: state_next = S_CWAIT;
      S_CWAIT: begin
        if (bus.c_odata_valid) begin
          state_next = S_RSP;
        end else if (tmo_last) begin
          state_next = S_RSP;
          tmo_hit    = 1'b1;
        end
      end
      S_RSP:   if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // NOTE: the wide datapath registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt    <= '0;
      key_loaded <= 1'b0;
      lat_op     <= OP_KEY;
      lat_data   <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      key_out_q  <= '0;
      key_mode_q <= '0;
      c_data_q   <= '0;
      c_ende_q   <= 1'b0;
      c_enable_q <= 1'b0;
    end else begin
      // Counter restarts on entry to any wait state, otherwise counts cycles spent waiting.
      if ((state_next != state) && (state_next inside {S_KWAIT, S_CWRDY, S_CWAIT}))
        tmo_cnt <= '0;
      else if (state inside {S_KWAIT, S_CWRDY, S_CWAIT})
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (accept) begin
        lat_op    <= op_t'(bus.cmd_op);
        lat_data  <= bus.cmd_data[127:0];
        rsp_tag_q <= bus.cmd_tag;
        if (op_t'(bus.cmd_op) == OP_KEY) begin
          key_out_q  <= bus.cmd_data;
          key_mode_q <= KEY_MODE;
        end
      end

      if ((state == S_KWAIT) && bus.key_ready)
        key_loaded <= 1'b1;

      if ((state == S_CWRDY) && (state_next == S_CSEND)) begin
        c_data_q   <= lat_data;
        c_ende_q   <= (lat_op == OP_DEC);
        c_enable_q <= 1'b1;
      end

      // Response payload is fixed on entry to RSP; IDLE->RSP is always a rejected command.
      if ((state != S_RSP) && (state_next == S_RSP)) begin
        rsp_err_q  <= (state == S_IDLE) || tmo_hit;
        rsp_data_q <= ((state == S_CWAIT) && bus.c_odata_valid) ? bus.c_odata : '0;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    bus.cmd_ready    = reset_n && (state == S_IDLE);
    bus.key_start    = (state == S_KSTART);
    bus.c_data_valid = (state == S_CSEND);
    bus.rsp_valid    = (state == S_RSP);
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_tag  = rsp_tag_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.key_out  = key_out_q;
  assign bus.key_mode = key_mode_q;
  assign bus.c_data   = c_data_q;
  assign bus.c_ende   = c_ende_q;
  assign bus.c_enable = c_enable_q;

  // ---------------------------------------------------------------- protocol properties
  a_key_start_pulse : assert property (@(posedge clk) disable iff (!reset_n)
    bus.key_start |=> !bus.key_start);

  a_c_valid_pulse : assert property (@(posedge clk) disable iff (!reset_n)
    bus.c_data_valid |=> !bus.c_data_valid);

  a_rsp_hold : assert property (@(posedge clk) disable iff (!reset_n)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_tag) && $stable(bus.rsp_err)));

endmodule

// File: tb/tb_aes_cmd_xactor.sv
// Directed bench for aes_cmd_xactor: a scoreboard queue of expected responses,
// a monitor that compares every accepted response, and simple key/cipher core models.
module tb_aes_cmd_xactor;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [127:0]     data;
  } rsp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  rsp_t sb[$];

  aes_cmd_xactor_if #(.TAG_W(TAG_W)) bus ();

  aes_cmd_xactor #(
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT),
    .KEY_MODE(2'b10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- response monitor
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 256'(bus.rsp_tag), 256'hdead);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_tag",  256'(bus.rsp_tag),  256'(e.tag));
        check("rsp_err",  256'(bus.rsp_err),  256'(e.err));
        check("rsp_data", 256'(bus.rsp_data), 256'(e.data));
      end
    end
  end

  // ---------------------------------------------------------------- bus observers
  int           ks_cnt;
  int           cv_cnt;
  logic [1:0]   mode_at_start;
  logic [255:0] key_at_start;
  logic         ende_at_send;
  logic [127:0] data_at_send;

  always @(negedge clk) begin
    if (bus.key_start) begin
      ks_cnt++;
      mode_at_start = bus.key_mode;
      key_at_start  = bus.key_out;
    end
    if (bus.c_data_valid) begin
      cv_cnt++;
      ende_at_send = bus.c_ende;
      data_at_send = bus.c_data;
    end
  end

  // ---------------------------------------------------------------- key-expansion model
  int key_lat;
  int key_cnt;

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.key_ready = 1'b0;
      key_cnt       = 0;
    end else if (bus.key_start) begin
      if (key_lat > 0) begin
        bus.key_ready = 1'b0;
        key_cnt       = key_lat;
      end else begin
        bus.key_ready = 1'b1;
      end
    end else if (key_cnt > 0) begin
      key_cnt--;
      if (key_cnt == 0) bus.key_ready = 1'b1;
    end
  end

  // ---------------------------------------------------------------- cipher model (canned vectors)
  int           core_lat;
  int           core_cnt;
  logic [127:0] core_res;

  always @(negedge clk) begin
    if (!reset_n) begin
      core_cnt          = -1;
      bus.c_odata_valid = 1'b0;
      bus.c_odata       = '0;
    end else begin
      bus.c_odata_valid = 1'b0;
      if (bus.c_data_valid) begin
        if (!bus.c_ende && bus.c_data == PT)     core_res = CT;
        else if (bus.c_ende && bus.c_data == CT) core_res = PT;
        else                                     core_res = ~bus.c_data;
        core_cnt = core_lat;
      end else if (core_cnt >= 0) begin
        core_cnt--;
      end
      if (core_cnt == 0) begin
        bus.c_odata_valid = 1'b1;
        bus.c_odata       = core_res;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic send_cmd(input logic [1:0] op, input logic [255:0] data, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_accept_timeout", 256'(0), 256'(1));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Cycle index (1 = cycle after the accept edge) on which rsp_valid is first seen.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("rsp_wait_timeout", 256'(0), 256'(1));
  endtask

  function automatic logic [255:0] out_vec();
    return 256'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, |bus.rsp_data, |bus.rsp_tag,
                 |bus.key_out, bus.key_mode, bus.key_start, |bus.c_data, bus.c_data_valid,
                 bus.c_ende, bus.c_enable});
  endfunction

  // ---------------------------------------------------------------- test sequence
  initial begin
    int   cyc;
    int   bad;
    rsp_t held;

    checks        = 0;
    failures      = 0;
    ks_cnt        = 0;
    cv_cnt        = 0;
    key_lat       = 10;
    core_lat      = 3;
    core_cnt      = -1;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;
    bus.c_ready   = 1'b1;
    bus.key_ready = 1'b0;
    bus.c_odata   = '0;
    bus.c_odata_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 256'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ENC with no key loaded
    sb.push_back('{tag: 4'd3, err: 1'b1, data: '0});
    send_cmd(2'b01, 256'(PT), 4'd3);
    wait_rsp(cyc);
    @(posedge clk); #1;
    check("nokey_key_start_pulses", 256'(ks_cnt), 256'(0));
    check("nokey_c_valid_pulses",   256'(cv_cnt), 256'(0));

    // KEY load, key_ready rises 10 cycles after key_start (cycle 1) -> RSP on cycle 12
    sb.push_back('{tag: 4'd1, err: 1'b0, data: '0});
    send_cmd(2'b00, KEY, 4'd1);
    wait_rsp(cyc);
    check("key_rsp_cycle",    256'(cyc), 256'(12));
    check("key_start_pulses", 256'(ks_cnt), 256'(1));
    check("key_mode",         256'(mode_at_start), 256'(2'b10));
    check("key_out",          key_at_start, KEY);
    @(posedge clk); #1;

    // ENC at minimum latency: RSP on cycle 5
    core_lat = 2;
    sb.push_back('{tag: 4'd2, err: 1'b0, data: CT});
    send_cmd(2'b01, 256'(PT), 4'd2);
    wait_rsp(cyc);
    check("enc_rsp_cycle",   256'(cyc), 256'(5));
    check("enc_c_ende",      256'(ende_at_send), 256'(0));
    check("enc_c_data",      256'(data_at_send), 256'(PT));
    check("enc_c_valid_cnt", 256'(cv_cnt), 256'(1));
    @(posedge clk); #1;

    // DEC of the ciphertext returns the plaintext
    core_lat = 3;
    sb.push_back('{tag: 4'd4, err: 1'b0, data: PT});
    send_cmd(2'b10, 256'(CT), 4'd4);
    wait_rsp(cyc);
    check("dec_c_ende",      256'(ende_at_send), 256'(1));
    check("dec_c_valid_cnt", 256'(cv_cnt), 256'(2));
    @(posedge clk); #1;
    check("c_enable_held",   256'(bus.c_enable), 256'(1));
    check("c_ende_held",     256'(bus.c_ende), 256'(1));

    // KEY reload with key_ready already high: RSP on cycle 4
    key_lat = 0;
    sb.push_back('{tag: 4'd5, err: 1'b0, data: '0});
    send_cmd(2'b00, ~KEY, 4'd5);
    wait_rsp(cyc);
    check("key_reload_cycle", 256'(cyc), 256'(4));
    check("key_reload_out",   bus.key_out, ~KEY);
    @(posedge clk); #1;

    // reserved op
    sb.push_back('{tag: 4'd6, err: 1'b1, data: '0});
    send_cmd(2'b11, 256'(PT), 4'd6);
    wait_rsp(cyc);
    @(posedge clk); #1;

    // c_ready held low: timeout 16 cycles after entering CWRDY (cycle 1)
    bus.c_ready = 1'b0;
    sb.push_back('{tag: 4'd7, err: 1'b1, data: '0});
    send_cmd(2'b01, 256'(PT), 4'd7);
    wait_rsp(cyc);
    check("timeout_cycle",      256'(cyc), 256'(17));
    check("timeout_no_c_valid", 256'(cv_cnt), 256'(2));
    @(posedge clk); #1;
    bus.c_ready = 1'b1;
    core_lat    = 2;
    sb.push_back('{tag: 4'd8, err: 1'b0, data: CT});
    send_cmd(2'b01, 256'(PT), 4'd8);
    wait_rsp(cyc);
    @(posedge clk); #1;

    // response back-pressure for 20 cycles
    bus.rsp_ready = 1'b0;
    sb.push_back('{tag: 4'd9, err: 1'b0, data: CT});
    send_cmd(2'b01, 256'(PT), 4'd9);
    wait_rsp(cyc);
    held = '{tag: bus.rsp_tag, err: bus.rsp_err, data: bus.rsp_data};
    check("stall_first_data", 256'(held.data), 256'(CT));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_tag != held.tag ||
          bus.rsp_err != held.err || bus.rsp_data != held.data)
        bad++;
    end
    check("stall_stable", 256'(bad), 256'(0));
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_release_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("stall_release_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    @(posedge clk); #1;

    // reset during CWAIT: no response, key forgotten
    core_lat = -1;
    send_cmd(2'b01, 256'(PT), 4'd10);
    repeat (6) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midop_reset_outputs", out_vec(), 256'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    core_lat = 2;
    sb.push_back('{tag: 4'd11, err: 1'b1, data: '0});
    send_cmd(2'b01, 256'(PT), 4'd11);
    wait_rsp(cyc);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got=%0t exp=finish", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/aes_cmd_xactor.md
Name: aes_cmd_xactor

Overview:
Synthesizable, emulation-friendly command transactor that drives the AES core's key bus and cipher bus. It sits directly downstream of the host-side command channel and directly upstream of the key-expansion and cipher ports. It accepts one command at a time (load key, encrypt, decrypt), runs the bus handshakes in hardware, and returns one tagged response per command.

Parameters:
TAG_W, 4, width of the command/response tag
TIMEOUT, 1024, maximum cycles spent waiting for the core before an error response is returned
KEY_MODE, 2'b10, value driven on key_mode (AES-256)

Ports:
clk  in  1  global clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  xactor accepts command this cycle
cmd_op  in  2  00=KEY, 01=ENC, 10=DEC, 11=reserved
cmd_data  in  256  key (KEY) or data in bits [127:0] (ENC/DEC)
cmd_tag  in  TAG_W  opaque tag, echoed on the response
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  128  cipher/plain result; 0 for KEY or on error
rsp_tag  out  TAG_W  tag of the originating command
rsp_err  out  1  1=timeout, reserved op, or ENC/DEC issued with no key loaded
key_out  out  256  key-bus key
key_mode  out  2  key-bus mode
key_start  out  1  key-expansion start pulse
key_ready  in  1  key-expansion done
c_data  out  128  cipher-bus data in
c_data_valid  out  1  cipher-bus input strobe
c_ende  out  1  0=encrypt, 1=decrypt
c_enable  out  1  cipher enable
c_ready  in  1  core can accept data
c_odata  in  128  core result
c_odata_valid  in  1  core result valid

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, key_loaded=0, timeout counter=0.
- Command handshake: cmd_ready=1 only in IDLE. A command is accepted when cmd_valid and cmd_ready are both high on a clk edge. cmd_data, cmd_op and cmd_tag are latched on acceptance.
- FSM states: IDLE, KSTART, KSKIP, KWAIT, CWRDY, CSEND, CSKIP, CWAIT, RSP.
- Op decode on accept:
  - KEY -> KSTART.
  - ENC/DEC with key_loaded=1 -> CWRDY.
  - ENC/DEC with key_loaded=0, or op 11 -> RSP with rsp_err=1 and rsp_data=0.
- KSTART: key_out=latched key, key_mode=KEY_MODE, key_start=1 for exactly one cycle -> KSKIP.
- KSKIP: one cycle; key_ready is ignored here -> KWAIT.
- KWAIT: when key_ready=1, set key_loaded=1 -> RSP with err=0, data=0.
- CWRDY: wait for c_ready=1 -> CSEND.
- CSEND: c_data=latched data, c_ende=(op==DEC), c_enable=1, c_data_valid=1 for exactly one cycle -> CSKIP.
- CSKIP: one cycle; c_odata_valid is ignored here -> CWAIT.
- CWAIT: when c_odata_valid=1, capture c_odata into rsp_data -> RSP with err=0.
- Minimum latency, accept to rsp_valid: KEY = 4 cycles if key_ready is already high in KWAIT; ENC/DEC = 5 cycles if c_ready and c_odata_valid are already high.
- Timeout: the counter clears on entry to KWAIT, CWRDY and CWAIT, and increments each cycle spent in those states. Reaching TIMEOUT -> RSP with err=1, data=0, and key_loaded is unchanged (a KEY timeout leaves it as it was).
- RSP: rsp_valid=1. rsp_data, rsp_tag and rsp_err are held stable until rsp_ready=1, then -> IDLE. rsp_valid drops the following cycle.
- Holding values:
  - c_enable stays 1 from the first CSEND until reset.
  - c_ende and c_data hold their last value between commands.
  - key_out and key_mode hold after KSTART.
- A KEY command while a key is already loaded reloads it; key_loaded stays 1 throughout.
- rsp_ready high while not in RSP has no effect. cmd_valid high outside IDLE is not accepted; the command is held by the producer.
- reset_n asserted mid-operation aborts immediately: no response is issued and key_loaded=0.

Test Plan:
- Reset, then ENC tag=3 data=00112233445566778899aabbccddeeff -> rsp err=1, tag=3, data=0, and key_start/c_data_valid never pulse.
- KEY cmd_data=000102...1e1f, tag=1, key_ready rises 10 cycles later -> exactly one key_start pulse with key_mode=2'b10; rsp err=0, tag=1 on the cycle after key_ready is seen.
- After key load, ENC data=00112233445566778899aabbccddeeff -> c_ende=0, one c_data_valid pulse after c_ready; rsp_data=8ea2b7ca516745bfeafc49904b496089. Then DEC with that value -> c_ende=1, rsp_data returns the plaintext.
- Hold c_ready=0 with TIMEOUT=16 -> rsp err=1 exactly 16 cycles after entering CWRDY; a following ENC still succeeds (key_loaded kept).
- rsp_ready held low 20 cycles -> rsp_valid and rsp payload stable throughout, cmd_ready=0; rsp_ready=1 -> cmd_ready=1 the next cycle.
- Assert reset_n during CWAIT -> all outputs 0 immediately; a subsequent ENC returns err=1 (key_loaded cleared).
